// File: rtl/pwm_cfg_sequencer.sv
// Holds one pending PWM configuration word and applies it to the active outputs only at a safe period boundary.
// Optional watchdog on the sync wait: define PWM_CFG_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | nothing pending, ready for a word
// WAIT_SYNC | word pending, waiting for the period boundary of the active mode
// APPLY     | pending word just loaded onto the active outputs
module pwm_cfg_sequencer #(
  parameter int REG_W          = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] cfg_in,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             evt_zero,
  input  logic             evt_top,
  output logic             pwm_onoff,
  output logic [1:0]       mask_mode,
  output logic [1:0]       count_mode,
  output logic             cnt_clear,
  output logic             cfg_applied,
  output logic             busy,
  output logic             timeout_err
);

  typedef enum logic [1:0] {IDLE, WAIT_SYNC, APPLY} state_t;

  state_t     state;
  logic [4:0] pend;
  logic [4:0] word;
  logic       accept;
  logic       sync_hit;
  logic       force_apply;
  logic       apply_now;
  logic       cfg_unused;

  assign cfg_unused = ^cfg_in;
  assign accept     = cfg_valid && cfg_ready;
  // a word accepted in the same cycle as the sync event wins over the pending one
  assign word       = accept ? cfg_in[4:0] : pend;

  always_comb begin
    sync_hit = 1'b0;
    case (count_mode)
      2'b00:        sync_hit = evt_top;
      2'b01, 2'b10: sync_hit = evt_zero;
      default:      sync_hit = 1'b1;
    endcase
  end

`ifdef PWM_CFG_TIMEOUT_EN
  localparam logic [19:0] TMR_LOAD = 20'(TIMEOUT_CYCLES - 1);
  logic [19:0] tmr;

  assign force_apply = (state == WAIT_SYNC) && !sync_hit && (tmr == '0);

  // reloaded every idle cycle so the first WAIT_SYNC cycle starts at full count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmr         <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == IDLE) tmr <= TMR_LOAD;
      else if (state == WAIT_SYNC && tmr != '0) tmr <= tmr - 1'b1;
      if (force_apply) timeout_err <= 1'b1;
    end
  end
`else
  assign force_apply = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign apply_now = (state == IDLE && accept && !pwm_onoff) ||
                     (state == WAIT_SYNC && (sync_hit || force_apply));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pend        <= '0;
      pwm_onoff   <= 1'b0;
      mask_mode   <= 2'b00;
      count_mode  <= 2'b00;
      cnt_clear   <= 1'b0;
      cfg_applied <= 1'b0;
      busy        <= 1'b0;
      cfg_ready   <= 1'b1;
    end else begin
      cnt_clear   <= 1'b0;
      cfg_applied <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            pend      <= cfg_in[4:0];
            busy      <= 1'b1;
            state     <= pwm_onoff ? WAIT_SYNC : APPLY;
            cfg_ready <= pwm_onoff;
          end
        end
        WAIT_SYNC: begin
          if (accept) pend <= cfg_in[4:0];
          if (apply_now) begin
            state     <= APPLY;
            cfg_ready <= 1'b0;
          end
        end
        APPLY: begin
          state     <= IDLE;
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
        end
      endcase
      if (apply_now) begin
        pwm_onoff   <= word[4];
        mask_mode   <= word[3:2];
        count_mode  <= word[1:0];
        cfg_applied <= 1'b1;
        // restart the counter on power-up or a running mode change
        cnt_clear   <= force_apply ||
                       (word[4] && (!pwm_onoff || word[1:0] != count_mode));
      end
    end
  end

endmodule

// File: doc/pwm_cfg_sequencer.md
Name: pwm_cfg_sequencer

Overview:
- Controls when a new PWM configuration word takes effect on the PWM counter and output stage.
- Accepts configuration words from the processor-side register block through a valid/ready handshake and holds one pending word.
- Applies the pending word to the active pwm_onoff / mask_mode / count_mode outputs only at a safe point of the PWM period. Result: no truncated or glitched periods.
- Issues a counter-clear pulse when the counter must restart.

Parameters:
- REG_W, 16, width of the configuration word. Must be >= 5. Bits [REG_W-1:5] are ignored.
- TIMEOUT_CYCLES, 65535, watchdog limit in clock cycles. Used only when PWM_CFG_TIMEOUT_EN is defined. Range 1..2^20-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low, sampled on the rising edge of clk.
- cfg_in  in  REG_W  configuration word. [1:0] count_mode, [3:2] mask_mode, [4] pwm_onoff.
- cfg_valid  in  1  cfg_in is valid.
- cfg_ready  out  1  block can accept a word.
- evt_zero  in  1  single-cycle pulse: counter at zero.
- evt_top  in  1  single-cycle pulse: counter at period top.
- pwm_onoff  out  1  active enable.
- mask_mode  out  2  active mask mode.
- count_mode  out  2  active count mode. 00 up, 01 down, 10 up-down, 11 reserved.
- cnt_clear  out  1  single-cycle pulse: counter reloads its start value.
- cfg_applied  out  1  single-cycle pulse: new configuration has taken effect.
- busy  out  1  a word is pending.
- timeout_err  out  1  sticky watchdog flag. Tied to 0 without PWM_CFG_TIMEOUT_EN.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - pwm_onoff=0, mask_mode=00, count_mode=00.
  - cnt_clear=0, cfg_applied=0, busy=0, timeout_err=0.
  - cfg_ready=1, state=IDLE.
  - Any pending word is discarded, including one asserted mid-operation.
- Handshake:
  - A word is accepted in a cycle where cfg_valid and cfg_ready are both 1.
  - cfg_ready=1 in IDLE and in WAIT_SYNC; it is 0 only in APPLY.
  - Accepting a word in WAIT_SYNC overwrites the pending word: the last accepted word wins.
- All outputs are registered.
- States: IDLE, WAIT_SYNC, APPLY.
  - IDLE, accept, active pwm_onoff=0 -> APPLY.
  - IDLE, accept, active pwm_onoff=1 -> WAIT_SYNC.
  - WAIT_SYNC -> APPLY on the sync event, selected by the ACTIVE count_mode:
    - 00 -> evt_top.
    - 01 -> evt_zero.
    - 10 -> evt_zero.
    - 11 -> immediate; the next cycle acts as the sync.
  - evt_zero and evt_top asserted together: either one qualifies.
  - Sync event in the same cycle as an accept in WAIT_SYNC: the newly accepted word is the one applied.
  - APPLY -> IDLE after 1 cycle.
- APPLY cycle actions:
  - Active outputs load the pending fields.
  - cfg_applied=1.
  - cnt_clear=1 if either holds:
    - transition off->on; or
    - pwm_onoff stays 1 and count_mode changes.
- Latency:
  - Accept in cycle N while off -> outputs updated and cfg_applied at N+1.
  - Sync event sampled in cycle M -> outputs updated at M+1.
- on->off is applied at the sync event, so the running period finishes.
- off->off still pulses cfg_applied.
- busy=1 in WAIT_SYNC and APPLY.

Optional Feature:
- Macro: PWM_CFG_TIMEOUT_EN.
- Defined:
  - A counter runs while in WAIT_SYNC and is cleared on entry.
  - When it reaches TIMEOUT_CYCLES with no sync event, the block forces APPLY, asserts cnt_clear in that APPLY cycle, and sets timeout_err.
  - timeout_err stays set until reset.
  - A sync event arriving in the same cycle the limit is reached takes priority: normal apply, no error.
- Not defined:
  - No counter; WAIT_SYNC waits indefinitely.
  - timeout_err is constant 0.

Test Plan:
- Reset, then accept cfg_in=5'b1_00_00 while off -> next cycle: pwm_onoff=1, cnt_clear=1, cfg_applied=1, count_mode=00.
- Active up mode, write 5'b1_01_00 -> outputs unchanged and busy=1 until evt_top; evt_zero alone has no effect; update in the cycle after evt_top; cnt_clear=0.
- Active up-down, write 5'b0_00_10, then 5'b1_11_10 before evt_zero -> only the second word is applied, one cycle after evt_zero; cfg_applied pulses exactly once.
- Active up mode, change count_mode to 01 -> applied after evt_top with cnt_clear=1. Accept coincident with evt_top -> the coincident word is applied.
- rst_n low while busy in WAIT_SYNC -> all outputs return to reset values; a later evt_top produces no cfg_applied.
- With PWM_CFG_TIMEOUT_EN and TIMEOUT_CYCLES=8 -> pending word, no events: forced apply on the 9th cycle after entering WAIT_SYNC, cnt_clear=1, timeout_err stays 1.
